// File: rtl/hex_scan_595.sv
// Multi-digit 7-segment scanner driving a daisy-chained 74HC595 pair, one digit per scan tick.
// Optional `LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 is always shown).
module hex_scan_595 #(
  parameter int unsigned DIGITS         = 8,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned SCLK_DIV       = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   disp_data,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  disp_en,
  output logic                  sh_cp,
  output logic                  st_cp,
  output logic                  ds,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned W    = 8 + DIGITS;
  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DivW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int unsigned BitW = $clog2(W);

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("hex_scan_595: DIGITS must be 1..8");
  end
  if (SCLK_DIV < 1) begin : g_bad_sclk_div
    $error("hex_scan_595: SCLK_DIV must be >= 1");
  end
  if (SCAN_DIV <= (W + 1) * 2 * SCLK_DIV) begin : g_bad_scan_div
    $error("hex_scan_595: SCAN_DIV too small for one full frame");
  end

  typedef enum logic [1:0] {StIdle, StShift, StLatch} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   scan_cnt_q;
  logic [IdxW-1:0]   idx_q;
  logic [DivW-1:0]   div_q, div_d;
  logic              half_q, half_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [W-1:0]      sreg_q, sreg_d;
  logic              pend_q, pend_d;
  logic [W-1:0]      pend_word_q, pend_word_d;
  logic              sh_cp_q, sh_cp_d, st_cp_q, st_cp_d;
  logic              frame_done_q, frame_done_d;

  logic              tick;
  logic              div_end;
  logic [3:0]        nib;
  logic              dp_bit, blk, lz_blank;
  logic [6:0]        seg;
  logic              dp;
  logic [DIGITS-1:0] sel;
  logic [W-1:0]      word_now;

  assign tick    = (scan_cnt_q == CntW'(SCAN_DIV - 1));
  assign div_end = (div_q == DivW'(SCLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
    end else begin
      scan_cnt_q <= tick ? '0 : scan_cnt_q + 1'b1;
      if (tick) idx_q <= (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Build the frame word for the digit selected by idx_q from the live inputs.
  always_comb begin
    nib      = 4'h0;
    dp_bit   = 1'b0;
    blk      = 1'b0;
    lz_blank = 1'b0;
    sel      = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        nib    = disp_data[4*i +: 4];
        dp_bit = dp_mask[i];
        blk    = blank_mask[i];
        sel[i] = disp_en;
      end
    end
`ifdef LEADING_ZERO_BLANK_EN
    begin : lzb
      logic run;
      run = 1'b1;
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
        run = run & (disp_data[4*i +: 4] == 4'h0);
        if (idx_q == IdxW'(i) && i != 0) lz_blank = run;
      end
    end
`endif
    unique case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    if (blk || lz_blank) seg = 7'h00;
    // Leading-zero blanking keeps the decimal point; blank_mask does not.
    dp       = blk ? 1'b0 : dp_bit;
    seg      = seg ^ {7{SEG_ACTIVE_LOW}};
    dp       = dp ^ SEG_ACTIVE_LOW;
    sel      = sel ^ {DIGITS{SEL_ACTIVE_LOW}};
    word_now = {dp, seg, sel};
  end

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    half_d       = half_q;
    bit_d        = bit_q;
    sreg_d       = sreg_q;
    pend_d       = pend_q;
    pend_word_d  = pend_word_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pend_q || tick) begin
          state_d = StShift;
          div_d   = '0;
          half_d  = 1'b0;
          bit_d   = '0;
          sreg_d  = pend_q ? pend_word_q : word_now;
        end
      end
      StShift: begin
        if (!div_end) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (!half_q) begin
            half_d = 1'b1;
          end else if (bit_q == BitW'(W - 1)) begin
            state_d = StLatch;
            half_d  = 1'b0;
          end else begin
            bit_d  = bit_q + 1'b1;
            half_d = 1'b0;
            sreg_d = {sreg_q[W-2:0], 1'b0};
          end
        end
      end
      StLatch: begin
        if (!div_end) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            state_d      = StIdle;
            half_d       = 1'b0;
            frame_done_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // One-deep backlog: a tick landing mid-frame is replayed right after it.
    if (state_q == StIdle && pend_q) begin
      pend_d = tick;
      if (tick) pend_word_d = word_now;
    end else if (state_q != StIdle && tick && !pend_q) begin
      pend_d      = 1'b1;
      pend_word_d = word_now;
    end

    sh_cp_d = (state_d == StShift) && half_d;
    st_cp_d = (state_d == StLatch) && !half_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      div_q        <= '0;
      half_q       <= 1'b0;
      bit_q        <= '0;
      sreg_q       <= '0;
      pend_q       <= 1'b0;
      pend_word_q  <= '0;
      sh_cp_q      <= 1'b0;
      st_cp_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      half_q       <= half_d;
      bit_q        <= bit_d;
      sreg_q       <= sreg_d;
      pend_q       <= pend_d;
      pend_word_q  <= pend_word_d;
      sh_cp_q      <= sh_cp_d;
      st_cp_q      <= st_cp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sh_cp      = sh_cp_q;
  assign st_cp      = st_cp_q;
  assign ds         = sreg_q[W-1];
  assign busy       = (state_q != StIdle);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_scan_595.sv
// Directed bench for hex_scan_595: an 8-digit common-anode instance and a 4-digit active-high one.
module tb_hex_scan_595;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] disp_data;
  logic [7:0]  dp_mask, blank_mask;
  logic [15:0] disp_data4;
  logic [3:0]  dp_mask4, blank_mask4;
  logic        disp_en;

  logic sh8, st8, ds8, busy8, fd8;
  logic sh4, st4, ds4, busy4, fd4;

  hex_scan_595 #(
    .DIGITS(8), .SCAN_DIV(80), .SCLK_DIV(2), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .disp_data(disp_data), .dp_mask(dp_mask), .blank_mask(blank_mask),
    .disp_en(disp_en), .sh_cp(sh8), .st_cp(st8), .ds(ds8), .busy(busy8), .frame_done(fd8)
  );

  hex_scan_595 #(
    .DIGITS(4), .SCAN_DIV(60), .SCLK_DIV(2), .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b0)
  ) dut4 (
    .clk(clk), .rst(rst), .disp_data(disp_data4), .dp_mask(dp_mask4), .blank_mask(blank_mask4),
    .disp_en(disp_en), .sh_cp(sh4), .st_cp(st4), .ds(ds4), .busy(busy4), .frame_done(fd4)
  );

  logic use4;
  logic m_sh, m_st, m_ds, m_busy, m_fd;
  assign m_sh   = use4 ? sh4   : sh8;
  assign m_st   = use4 ? st4   : st8;
  assign m_ds   = use4 ? ds4   : ds8;
  assign m_busy = use4 ? busy4 : busy8;
  assign m_fd   = use4 ? fd4   : fd8;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [15:0] word;
  int          nbits, st_at, total, st_pulses;
  logic        fd_ok, idle_st;

  // Waits for the next frame, records bits on sh_cp rises and timing relative to busy rising.
  task automatic capture();
    int   guard, cyc;
    logic psh, pst;
    word = '0; nbits = 0; st_at = -1; total = -1; st_pulses = 0; fd_ok = 1'b0; idle_st = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!m_busy && guard < 400) begin
      if (m_st) idle_st = 1'b1;
      @(negedge clk);
      guard++;
    end
    if (!m_busy) begin
      check("busy_timeout", 32'(m_busy), 32'd1);
      return;
    end
    cyc = 0; psh = 1'b0; pst = 1'b0;
    while (m_busy && cyc < 200) begin
      if (m_sh && !psh) begin
        word = {word[14:0], m_ds};
        nbits++;
      end
      if (m_st && !pst) begin
        st_pulses++;
        if (st_at < 0) st_at = cyc;
      end
      psh = m_sh; pst = m_st;
      @(negedge clk);
      cyc++;
    end
    total = cyc;
    fd_ok = m_fd;
    @(negedge clk);
    fd_ok = fd_ok && !m_fd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [15:0] seq_exp [9] = '{16'hC0FE, 16'hF9FD, 16'hA4FB, 16'hB0F7, 16'h99EF,
                               16'h92DF, 16'h82BF, 16'hF87F, 16'hC0FE};
`ifdef LEADING_ZERO_BLANK_EN
  logic [15:0] lz_exp [8] = '{16'hC0FE, 16'h92FD, 16'hFFFB, 16'hFFF7, 16'hFFEF,
                              16'hFFDF, 16'hFFBF, 16'hFF7F};
`else
  logic [15:0] lz_exp [8] = '{16'hC0FE, 16'h92FD, 16'hC0FB, 16'hC0F7, 16'hC0EF,
                              16'hC0DF, 16'hC0BF, 16'hC07F};
`endif

  initial begin
    int guard;
    rst         = 1'b1;
    use4        = 1'b0;
    disp_data   = 32'h7654_3210;
    dp_mask     = 8'h00;
    blank_mask  = 8'h00;
    disp_en     = 1'b1;
    disp_data4  = 16'h000A;
    dp_mask4    = 4'b0001;
    blank_mask4 = 4'b0000;

    @(negedge clk);
    @(negedge clk);
    check("rst_sh_cp", 32'(sh8), 32'd0);
    check("rst_st_cp", 32'(st8), 32'd0);
    check("rst_ds", 32'(ds8), 32'd0);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_frame_done", 32'(fd8), 32'd0);
    rst = 1'b0;

    // Full scan of all eight digits and the wrap back to digit 0.
    for (int k = 0; k < 9; k++) begin
      capture();
      check($sformatf("scan_word%0d", k), 32'(word), 32'(seq_exp[k]));
      check($sformatf("scan_fd%0d", k), 32'(fd_ok), 32'd1);
      if (k == 0) begin
        check("frame_bits", 32'(nbits), 32'd16);
        check("st_rise_cyc", 32'(st_at), 32'd64);
        check("frame_len", 32'(total), 32'd68);
        check("st_pulses", 32'(st_pulses), 32'd1);
      end
    end

    // Reset five bits into a frame.
    guard = 0;
    while (!busy8 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("busy_before_abort", 32'(busy8), 32'd1);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_sh_cp", 32'(sh8), 32'd0);
    check("abort_st_cp", 32'(st8), 32'd0);
    check("abort_ds", 32'(ds8), 32'd0);
    check("abort_busy", 32'(busy8), 32'd0);
    rst = 1'b0;
    capture();
    check("abort_no_st", 32'(idle_st), 32'd0);
    check("abort_next_word", 32'(word), 32'hC0FE);

    // Blanked digit with its decimal point requested.
    disp_data  = 32'h7654_3810;
    dp_mask    = 8'h04;
    blank_mask = 8'h04;
    capture();
    check("blank_d1", 32'(word), 32'hF9FD);
    capture();
    check("blank_d2", 32'(word), 32'hFFFB);

    // Display disabled: every sel bit inactive.
    disp_en    = 1'b0;
    blank_mask = 8'h00;
    dp_mask    = 8'h00;
    capture();
    check("dis_d3", 32'(word), 32'hB0FF);
    capture();
    check("dis_d4", 32'(word), 32'h99FF);
    disp_en = 1'b1;

    // Leading zeros.
    disp_data = 32'h0000_0050;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      capture();
      check($sformatf("lz_word%0d", k), 32'(word), 32'(lz_exp[k]));
    end

    // Four-digit active-high instance.
    do_reset();
    use4 = 1'b1;
    capture();
    check("d4_word", 32'(word), 32'hF71);
    check("d4_bits", 32'(nbits), 32'd12);
    check("d4_st_rise", 32'(st_at), 32'd48);
    check("d4_len", 32'(total), 32'd52);
    check("d4_fd", 32'(fd_ok), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
